// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage types: result-select enum and RISC-V load funct3 encodings.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: picks byte/half by offset and sign- or zero-extends.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Reserved encodings (011/110/111) fall through to the full-word path.
    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback mux with register-file write and bypass ports.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RET_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m_valid,
    input  logic            m_rd_we,
    input  logic [4:0]      m_rd,
    input  logic [1:0]      m_wb_sel,
    input  logic [2:0]      m_funct3,
    input  logic [1:0]      m_addr_lo,
    input  logic [XLEN-1:0] m_alu_res,
    input  logic [XLEN-1:0] m_mem_rdata,
    input  logic [XLEN-1:0] m_pc4,
    input  logic [XLEN-1:0] m_csr_rdata,
    input  logic            stall,
    input  logic            flush,
    output logic            rf_we,
    output logic [4:0]      rf_wr,
    output logic [XLEN-1:0] rf_wd,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            retire
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [RET_W-1:0] instret
`endif
);

    if (RET_W < 1) begin : g_ret_w_check
        $error("wb_stage: RET_W must be at least 1");
    end

    logic            valid_q;
    logic            rd_we_q;
    logic [4:0]      rd_q;
    wb_sel_e         wb_sel_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [XLEN-1:0] alu_res_q;
    logic [XLEN-1:0] mem_rdata_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] csr_rdata_q;
    logic [XLEN-1:0] load_data;

    // Flush only kills valid; the payload fields may stay stale because nothing
    // downstream looks at them without valid_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rd_we_q     <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= WB_ALU;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            alu_res_q   <= '0;
            mem_rdata_q <= '0;
            pc4_q       <= '0;
            csr_rdata_q <= '0;
        end else if (flush) begin
            valid_q     <= 1'b0;
        end else if (!stall) begin
            valid_q     <= m_valid;
            rd_we_q     <= m_rd_we;
            rd_q        <= m_rd;
            wb_sel_q    <= wb_sel_e'(m_wb_sel);
            funct3_q    <= m_funct3;
            addr_lo_q   <= m_addr_lo;
            alu_res_q   <= m_alu_res;
            mem_rdata_q <= m_mem_rdata;
            pc4_q       <= m_pc4;
            csr_rdata_q <= m_csr_rdata;
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .rdata   (mem_rdata_q),
        .data    (load_data)
    );

    always_comb begin
        rf_wd = alu_res_q;
        case (wb_sel_q)
            WB_ALU:  rf_wd = alu_res_q;
            WB_MEM:  rf_wd = load_data;
            WB_PC4:  rf_wd = pc4_q;
            WB_CSR:  rf_wd = csr_rdata_q;
            default: rf_wd = alu_res_q;
        endcase
    end

    // A stalled instruction is held for another cycle, so it must not write or retire yet.
    assign rf_we     = valid_q & rd_we_q & (rd_q != 5'd0) & ~stall;
    assign rf_wr     = rd_q;
    assign retire    = valid_q & ~stall;
    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_wr;
    assign fwd_data  = rf_wd;

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= '0;
        else if (retire)
            instret <= instret + RET_W'(1);
    end
`endif

endmodule
